// File: rtl/tick_divider_bank.sv
// Bank of independent runtime-programmable tick dividers. Each channel emits a divided clock
// and a one-cycle period-start tick; config writes to a running channel wait for a boundary.
module tick_divider_bank #(
   parameter int unsigned CHANNELS     = 4,
   parameter int unsigned WIDTH        = 24,
   parameter int unsigned DEFAULT_DIV  = 100,
   parameter int unsigned DEFAULT_HIGH = 50,
   parameter int unsigned CH_W         = 2
) (
   input  logic                i_clk,
   input  logic                reset,
   input  logic [CHANNELS-1:0] i_enable,
   input  logic                i_cfg_we,
   input  logic [CH_W-1:0]     i_cfg_ch,
   input  logic [WIDTH-1:0]    i_cfg_div,
   input  logic [WIDTH-1:0]    i_cfg_high,
   output logic [CHANNELS-1:0] o_clk,
   output logic [CHANNELS-1:0] o_tick,
   output logic [CHANNELS-1:0] o_cfg_pending
);

   localparam logic [WIDTH-1:0] DefPer  = (DEFAULT_DIV < 2) ? WIDTH'(2) : WIDTH'(DEFAULT_DIV);
   localparam logic [WIDTH-1:0] DefHigh = WIDTH'(DEFAULT_HIGH);

   logic [CHANNELS-1:0] running_q, running_d;
   logic [CHANNELS-1:0] pend_v_q, pend_v_d;
   logic [CHANNELS-1:0] clk_q, clk_d;
   logic [CHANNELS-1:0] tick_q, tick_d;

   logic [WIDTH-1:0] cnt_q      [CHANNELS];
   logic [WIDTH-1:0] cnt_d      [CHANNELS];
   logic [WIDTH-1:0] per_q      [CHANNELS];
   logic [WIDTH-1:0] per_d      [CHANNELS];
   logic [WIDTH-1:0] hi_q       [CHANNELS];
   logic [WIDTH-1:0] hi_d       [CHANNELS];
   logic [WIDTH-1:0] pend_per_q [CHANNELS];
   logic [WIDTH-1:0] pend_per_d [CHANNELS];
   logic [WIDTH-1:0] pend_hi_q  [CHANNELS];
   logic [WIDTH-1:0] pend_hi_d  [CHANNELS];

   logic [WIDTH-1:0] cfg_div_clamped;
   logic [CHANNELS-1:0] wr_hit;
   logic [CHANNELS-1:0] load;

   assign cfg_div_clamped = (i_cfg_div < WIDTH'(2)) ? WIDTH'(2) : i_cfg_div;

   // Out-of-range channel selects match no channel, so the write is dropped.
   always_comb begin
      wr_hit = '0;
      for (int c = 0; c < int'(CHANNELS); c++) begin
         wr_hit[c] = i_cfg_we && (i_cfg_ch == CH_W'(c));
      end
   end

   always_comb begin
      running_d = running_q;
      pend_v_d  = pend_v_q;
      clk_d     = '0;
      tick_d    = '0;
      load      = '0;
      for (int c = 0; c < int'(CHANNELS); c++) begin
         cnt_d[c]      = cnt_q[c];
         per_d[c]      = per_q[c];
         hi_d[c]       = hi_q[c];
         pend_per_d[c] = pend_per_q[c];
         pend_hi_d[c]  = pend_hi_q[c];

         if (!i_enable[c]) begin
            running_d[c] = 1'b0;
            cnt_d[c]     = '0;
         end else if (!running_q[c] || (cnt_q[c] == per_q[c] - WIDTH'(1))) begin
            running_d[c] = 1'b1;
            cnt_d[c]     = '0;
            tick_d[c]    = 1'b1;
            load[c]      = pend_v_q[c];
         end else begin
            cnt_d[c] = cnt_q[c] + WIDTH'(1);
         end

         // The boundary consumes the staged value held before this edge.
         if (load[c]) begin
            per_d[c]    = pend_per_q[c];
            hi_d[c]     = pend_hi_q[c];
            pend_v_d[c] = 1'b0;
         end

         // Writes to a running or starting channel wait for the next boundary.
         if (wr_hit[c]) begin
            if (running_q[c] || i_enable[c]) begin
               pend_per_d[c] = cfg_div_clamped;
               pend_hi_d[c]  = i_cfg_high;
               pend_v_d[c]   = 1'b1;
            end else begin
               per_d[c] = cfg_div_clamped;
               hi_d[c]  = i_cfg_high;
            end
         end

         clk_d[c] = i_enable[c] && (cnt_d[c] < hi_d[c]);
      end
   end

   always_ff @(posedge i_clk) begin
      if (reset) begin
         running_q <= '0;
         pend_v_q  <= '0;
         clk_q     <= '0;
         tick_q    <= '0;
         for (int c = 0; c < int'(CHANNELS); c++) begin
            cnt_q[c]      <= '0;
            per_q[c]      <= DefPer;
            hi_q[c]       <= DefHigh;
            pend_per_q[c] <= DefPer;
            pend_hi_q[c]  <= DefHigh;
         end
      end else begin
         running_q <= running_d;
         pend_v_q  <= pend_v_d;
         clk_q     <= clk_d;
         tick_q    <= tick_d;
         for (int c = 0; c < int'(CHANNELS); c++) begin
            cnt_q[c]      <= cnt_d[c];
            per_q[c]      <= per_d[c];
            hi_q[c]       <= hi_d[c];
            pend_per_q[c] <= pend_per_d[c];
            pend_hi_q[c]  <= pend_hi_d[c];
         end
      end
   end

   assign o_clk         = clk_q;
   assign o_tick        = tick_q;
   assign o_cfg_pending = pend_v_q;

endmodule

// File: tb/tb_tick_divider_bank.sv
// Scoreboard bench for tick_divider_bank: a behavioural model queues expected outputs per edge,
// plus directed period/duty/pending counts for each scenario.
module tb_tick_divider_bank;

   localparam int NCH = 4;
   localparam int W   = 24;
   localparam int CW  = 3;

   logic           i_clk = 1'b0;
   logic           reset;
   logic [NCH-1:0] i_enable;
   logic           i_cfg_we;
   logic [CW-1:0]  i_cfg_ch;
   logic [W-1:0]   i_cfg_div;
   logic [W-1:0]   i_cfg_high;
   logic [NCH-1:0] o_clk;
   logic [NCH-1:0] o_tick;
   logic [NCH-1:0] o_cfg_pending;

   tick_divider_bank #(
      .CHANNELS    (NCH),
      .WIDTH       (W),
      .DEFAULT_DIV (100),
      .DEFAULT_HIGH(50),
      .CH_W        (CW)
   ) dut (
      .i_clk        (i_clk),
      .reset        (reset),
      .i_enable     (i_enable),
      .i_cfg_we     (i_cfg_we),
      .i_cfg_ch     (i_cfg_ch),
      .i_cfg_div    (i_cfg_div),
      .i_cfg_high   (i_cfg_high),
      .o_clk        (o_clk),
      .o_tick       (o_tick),
      .o_cfg_pending(o_cfg_pending)
   );

   always #5 i_clk = ~i_clk;

   typedef struct {
      logic [NCH-1:0] clk;
      logic [NCH-1:0] tick;
      logic [NCH-1:0] pend;
   } exp_t;

   exp_t sb[$];

   int unsigned m_cnt  [NCH];
   int unsigned m_per  [NCH];
   int unsigned m_hi   [NCH];
   int unsigned m_pper [NCH];
   int unsigned m_phi  [NCH];
   bit          m_run  [NCH];
   bit          m_pv   [NCH];

   int n_checks = 0;
   int n_errs   = 0;

   task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_checks++;
      if (obs !== exp) begin
         n_errs++;
         $display("FAIL %s: got %0d expected %0d", tag, obs, exp);
      end
   endtask

   // Behavioural model of one edge, evaluated with the inputs present at that edge.
   task automatic model_step();
      exp_t        e;
      bit          was_run;
      bit          wr;
      int unsigned nn;
      for (int c = 0; c < NCH; c++) begin
         e.tick[c] = 1'b0;
         e.clk[c]  = 1'b0;
         if (reset) begin
            m_run[c] = 0; m_cnt[c] = 0; m_pv[c] = 0; m_per[c] = 100; m_hi[c] = 50;
         end else begin
            was_run = m_run[c];
            wr = i_cfg_we && (int'(i_cfg_ch) == c);
            nn = (i_cfg_div < 2) ? 2 : int'(i_cfg_div);
            if (!i_enable[c]) begin
               m_run[c] = 0;
               m_cnt[c] = 0;
            end else if (!was_run || m_cnt[c] + 1 == m_per[c]) begin
               m_run[c]  = 1;
               m_cnt[c]  = 0;
               e.tick[c] = 1'b1;
               if (m_pv[c]) begin
                  m_per[c] = m_pper[c]; m_hi[c] = m_phi[c]; m_pv[c] = 0;
               end
            end else begin
               m_cnt[c]++;
            end
            if (wr) begin
               if (was_run || i_enable[c]) begin
                  m_pper[c] = nn; m_phi[c] = int'(i_cfg_high); m_pv[c] = 1;
               end else begin
                  m_per[c] = nn; m_hi[c] = int'(i_cfg_high);
               end
            end
            e.clk[c] = i_enable[c] && (m_cnt[c] < m_hi[c]);
         end
         e.pend[c] = m_pv[c];
      end
      sb.push_back(e);
   endtask

   task automatic cyc();
      exp_t e;
      model_step();
      @(posedge i_clk);
      #1;
      if (sb.size() == 0) begin
         check_eq("sb_empty", 32'd1, 32'd0);
      end else begin
         e = sb.pop_front();
         check_eq("clk", 32'(o_clk), 32'(e.clk));
         check_eq("tick", 32'(o_tick), 32'(e.tick));
         check_eq("pend", 32'(o_cfg_pending), 32'(e.pend));
      end
   endtask

   task automatic cfg_write(input int ch, input int div, input int high);
      i_cfg_we   = 1'b1;
      i_cfg_ch   = CW'(ch);
      i_cfg_div  = W'(div);
      i_cfg_high = W'(high);
      cyc();
      i_cfg_we = 1'b0;
   endtask

   task automatic run_count(input int ch, input int n, output int ticks, output int highs,
                            output int pends);
      ticks = 0; highs = 0; pends = 0;
      for (int i = 0; i < n; i++) begin
         cyc();
         ticks += int'(o_tick[ch]);
         highs += int'(o_clk[ch]);
         pends += int'(o_cfg_pending[ch]);
      end
   endtask

   task automatic wait_tick(input int ch, input int bound);
      bit found = 0;
      for (int i = 0; i < bound && !found; i++) begin
         cyc();
         if (o_tick[ch]) found = 1;
      end
      check_eq("wait_tick", 32'(found), 32'd1);
   endtask

   int tk, hi, pd;

   initial begin
      for (int c = 0; c < NCH; c++) begin
         m_cnt[c] = 0; m_per[c] = 100; m_hi[c] = 50; m_pper[c] = 0; m_phi[c] = 0;
         m_run[c] = 0; m_pv[c] = 0;
      end
      reset = 1'b1; i_enable = '0; i_cfg_we = 1'b0; i_cfg_ch = '0;
      i_cfg_div = '0; i_cfg_high = '0;
      cyc();
      cyc();
      check_eq("rst_clk", 32'(o_clk), 32'd0);
      check_eq("rst_tick", 32'(o_tick), 32'd0);
      reset = 1'b0;
      cyc();

      // Defaults on ch0: 100-cycle period, 50 high.
      i_enable[0] = 1'b1;
      cyc();
      check_eq("ch0_first_tick", 32'(o_tick[0]), 32'd1);
      check_eq("ch0_first_clk", 32'(o_clk[0]), 32'd1);
      run_count(0, 100, tk, hi, pd);
      check_eq("ch0_ticks_p1", 32'(tk), 32'd1);
      check_eq("ch0_highs_p1", 32'(hi), 32'd50);
      check_eq("ch0_tick_at_100", 32'(o_tick[0]), 32'd1);
      run_count(0, 100, tk, hi, pd);
      check_eq("ch0_ticks_p2", 32'(tk), 32'd1);
      check_eq("ch0_highs_p2", 32'(hi), 32'd50);

      // ch1: N=10 H=3, then reprogram N=6 H=2 at cnt=4.
      cfg_write(1, 10, 3);
      check_eq("ch1_idle_nopend", 32'(o_cfg_pending[1]), 32'd0);
      i_enable[1] = 1'b1;
      cyc();
      check_eq("ch1_start_tick", 32'(o_tick[1]), 32'd1);
      for (int i = 0; i < 4; i++) cyc();
      cfg_write(1, 6, 2);
      check_eq("ch1_pend_set", 32'(o_cfg_pending[1]), 32'd1);
      run_count(1, 4, tk, hi, pd);
      check_eq("ch1_old_no_tick", 32'(tk), 32'd0);
      check_eq("ch1_pend_held", 32'(pd), 32'd4);
      cyc();
      check_eq("ch1_boundary_tick", 32'(o_tick[1]), 32'd1);
      check_eq("ch1_pend_clear", 32'(o_cfg_pending[1]), 32'd0);
      run_count(1, 6, tk, hi, pd);
      check_eq("ch1_new_ticks", 32'(tk), 32'd1);
      check_eq("ch1_new_highs", 32'(hi), 32'd2);

      // ch2: N=1 clamps to 2, H=0 keeps clk low; then H=5 keeps clk high.
      cfg_write(2, 1, 0);
      i_enable[2] = 1'b1;
      cyc();
      check_eq("ch2_start_tick", 32'(o_tick[2]), 32'd1);
      run_count(2, 10, tk, hi, pd);
      check_eq("ch2_ticks", 32'(tk), 32'd5);
      check_eq("ch2_h0_highs", 32'(hi), 32'd0);
      cfg_write(2, 1, 5);
      check_eq("ch2_pend_set", 32'(o_cfg_pending[2]), 32'd1);
      run_count(2, 2, tk, hi, pd);
      run_count(2, 10, tk, hi, pd);
      check_eq("ch2_hbig_highs", 32'(hi), 32'd10);
      check_eq("ch2_hbig_ticks", 32'(tk), 32'd5);

      // ch1: write coinciding with the boundary edge (N=8 -> N=4 at cnt=7).
      cfg_write(1, 8, 4);
      wait_tick(1, 20);
      check_eq("ch1_n8_applied", 32'(o_cfg_pending[1]), 32'd0);
      for (int i = 0; i < 7; i++) cyc();
      cfg_write(1, 4, 1);
      check_eq("ch1_edge_tick", 32'(o_tick[1]), 32'd1);
      check_eq("ch1_edge_pend", 32'(o_cfg_pending[1]), 32'd1);
      run_count(1, 8, tk, hi, pd);
      check_eq("ch1_still_n8", 32'(tk), 32'd1);
      check_eq("ch1_pend_for_7", 32'(pd), 32'd7);
      check_eq("ch1_tick_at_8", 32'(o_tick[1]), 32'd1);
      run_count(1, 4, tk, hi, pd);
      check_eq("ch1_n4_ticks", 32'(tk), 32'd1);
      check_eq("ch1_n4_highs", 32'(hi), 32'd1);

      // ch3: disable at cnt=5 for 3 cycles, then restart.
      cfg_write(3, 12, 6);
      i_enable[3] = 1'b1;
      cyc();
      for (int i = 0; i < 5; i++) cyc();
      i_enable[3] = 1'b0;
      cyc();
      check_eq("ch3_off_clk", 32'(o_clk[3]), 32'd0);
      check_eq("ch3_off_tick", 32'(o_tick[3]), 32'd0);
      run_count(3, 2, tk, hi, pd);
      check_eq("ch3_off_highs", 32'(hi + tk), 32'd0);
      i_enable[3] = 1'b1;
      cyc();
      check_eq("ch3_restart_tick", 32'(o_tick[3]), 32'd1);
      check_eq("ch3_restart_clk", 32'(o_clk[3]), 32'd1);

      // Mid-run reset clears a pending write and restores defaults.
      cfg_write(0, 20, 10);
      check_eq("ch0_pend_before_rst", 32'(o_cfg_pending[0]), 32'd1);
      reset = 1'b1;
      cyc();
      check_eq("mid_rst_clk", 32'(o_clk), 32'd0);
      check_eq("mid_rst_tick", 32'(o_tick), 32'd0);
      check_eq("mid_rst_pend", 32'(o_cfg_pending), 32'd0);
      reset = 1'b0;
      i_enable = '0;
      cyc();
      i_enable = 4'b0011;
      cyc();
      check_eq("post_rst_tick", 32'(o_tick), 32'b0011);
      run_count(0, 100, tk, hi, pd);
      check_eq("post_rst_ticks", 32'(tk), 32'd1);
      check_eq("post_rst_highs", 32'(hi), 32'd50);

      // Out-of-range channel select is ignored.
      cfg_write(NCH, 3, 1);
      check_eq("oor_no_pend", 32'(o_cfg_pending), 32'd0);
      run_count(0, 100, tk, hi, pd);
      check_eq("oor_ch0_ticks", 32'(tk), 32'd1);
      check_eq("oor_ch0_highs", 32'(hi), 32'd50);
      i_enable[2] = 1'b1;
      cyc();
      run_count(2, 100, tk, hi, pd);
      check_eq("oor_ch2_ticks", 32'(tk), 32'd1);
      check_eq("oor_ch2_highs", 32'(hi), 32'd50);

      $display("Result: errors=%0d of %0d checks", n_errs, n_checks);
      $finish;
   end

endmodule
